// File: rtl/seg7_mux_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_mux_driver : time-multiplexed N-digit seven-segment display driver   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int HEX_EN       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic                    sh_lz_q, sh_lz_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;
  logic                    frame_start_q, frame_start_d;

  logic                    snap;
  logic                    running_zero;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic [NUM_DIGITS-1:0]   sel;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_lzb;

  function automatic logic [6:0] seg_of(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b100_0000;
      4'h1: s = 7'b111_1001;
      4'h2: s = 7'b010_0100;
      4'h3: s = 7'b011_0000;
      4'h4: s = 7'b001_1001;
      4'h5: s = 7'b001_0010;
      4'h6: s = 7'b000_0010;
      4'h7: s = 7'b111_1000;
      4'h8: s = 7'b000_0000;
      4'h9: s = 7'b001_0000;
      4'hA: s = 7'b000_1000;
      4'hB: s = 7'b000_0011;
      4'hC: s = 7'b100_0110;
      4'hD: s = 7'b010_0001;
      4'hE: s = 7'b000_0110;
      default: s = 7'b000_1110;
    endcase
    if (HEX_EN == 0 && code > 4'd9) s = 7'b111_1111;
    return s;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    snap          = (cnt_q == '0) && (idx_q == '0);
    frame_start_d = snap;
    sh_value_d    = snap ? value    : sh_value_q;
    sh_dp_d       = snap ? dp       : sh_dp_q;
    sh_en_d       = snap ? digit_en : sh_en_q;
    sh_lz_d       = snap ? lz_blank : sh_lz_q;

    // zero_from[i]: digit i and every more-significant digit hold code 0
    running_zero = 1'b1;
    zero_from    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      running_zero = running_zero & (sh_value_q[4*i +: 4] == 4'h0);
      zero_from[i] = running_zero;
    end

    sel      = '0;
    cur_code = 4'h0;
    cur_dp   = 1'b0;
    cur_en   = 1'b0;
    cur_lzb  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel[i]   = 1'b1;
        cur_code = sh_value_q[4*i +: 4];
        cur_dp   = sh_dp_q[i];
        cur_en   = sh_en_q[i];
        cur_lzb  = sh_lz_q && (i != 0) && zero_from[i];
      end
    end

    anode_d   = '1;
    cathode_d = 8'hFF;
    if ((cnt_q >= CW'(BLANK_CYCLES)) && cur_en && !cur_lzb) begin
      anode_d   = ~sel;
      cathode_d = {~cur_dp, seg_of(cur_code)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      sh_value_q    <= '0;
      sh_dp_q       <= '0;
      sh_en_q       <= '0;
      sh_lz_q       <= 1'b0;
      anode_q       <= '1;
      cathode_q     <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sh_value_q    <= sh_value_d;
      sh_dp_q       <= sh_dp_d;
      sh_en_q       <= sh_en_d;
      sh_lz_q       <= sh_lz_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode       = anode_q;
  assign cathode     = cathode_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg7_mux_driver : directed self-checking bench for seg7_mux_driver     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_seg7_mux_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  anode, anode2;
  logic [7:0]  cathode, cathode2;
  logic        frame_start, frame_start2;
  logic        mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .HEX_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .digit_en(digit_en),
    .lz_blank(lz_blank), .anode(anode), .cathode(cathode), .frame_start(frame_start)
  );

  seg7_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .HEX_EN(0)
  ) dut_nohex (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .digit_en(digit_en),
    .lz_blank(lz_blank), .anode(anode2), .cathode(cathode2), .frame_start(frame_start2)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Never more than one digit selected, in either instance
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot_anode", 8'($countones(~anode) <= 1), 8'd1);
      chk("onehot_anode_nohex", 8'($countones(~anode2) <= 1), 8'd1);
    end
  end

  task automatic wait_frame(input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1'b1;
    end
    chk({tag, "_frame_start_seen"}, {7'd0, found}, 8'd1);
  endtask

  // Called on the negedge where frame_start is seen; output at step k reflects frame position k.
  task automatic check_frame(input string tag,
                             input logic [31:0] ec1, input logic [3:0] vis1,
                             input logic [31:0] ec2, input logic [3:0] vis2,
                             input logic do_mid, input logic [15:0] mid_val);
    int slot, c;
    logic [3:0] ea1, ea2;
    logic [7:0] eca1, eca2;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      slot = k / 8;
      c    = k % 8;
      ea1 = 4'hF; eca1 = 8'hFF;
      ea2 = 4'hF; eca2 = 8'hFF;
      if (c >= 2 && vis1[slot]) begin ea1[slot] = 1'b0; eca1 = ec1[slot*8 +: 8]; end
      if (c >= 2 && vis2[slot]) begin ea2[slot] = 1'b0; eca2 = ec2[slot*8 +: 8]; end
      chk($sformatf("%s_k%0d_anode", tag, k), {4'h0, anode}, {4'h0, ea1});
      chk($sformatf("%s_k%0d_cathode", tag, k), cathode, eca1);
      chk($sformatf("%s_k%0d_frame_start", tag, k), {7'd0, frame_start}, {7'd0, k == 0});
      chk($sformatf("%s_k%0d_anode_nohex", tag, k), {4'h0, anode2}, {4'h0, ea2});
      chk($sformatf("%s_k%0d_cathode_nohex", tag, k), cathode2, eca2);
      if (do_mid && k == 12) value = mid_val;
    end
  endtask

  initial begin
    value    = 16'h1234;
    dp       = 4'b0000;
    digit_en = 4'hF;
    lz_blank = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("reset_anode", {4'h0, anode}, 8'h0F);
    chk("reset_cathode", cathode, 8'hFF);
    chk("reset_frame_start", {7'd0, frame_start}, 8'd0);
    chk("reset_anode_nohex", {4'h0, anode2}, 8'h0F);

    // First frame after release; digits 3..0 = 1,2,3,4
    rst_n = 1'b1;
    wait_frame("f1");
    check_frame("f1_1234", 32'hF9_A4_B0_99, 4'hF, 32'hF9_A4_B0_99, 4'hF, 1'b0, 16'h0);

    // Mid-frame change during digit 1 slot must not leak into this frame
    wait_frame("f2");
    check_frame("f2_mid", 32'hF9_A4_B0_99, 4'hF, 32'hF9_A4_B0_99, 4'hF, 1'b1, 16'h5678);
    wait_frame("f3");
    check_frame("f3_5678", 32'h92_82_F8_80, 4'hF, 32'h92_82_F8_80, 4'hF, 1'b0, 16'h0);

    // Asynchronous reset in the middle of a lit slot
    wait_frame("f4");
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_anode", {4'h0, anode}, 8'h0F);
    chk("midreset_cathode", cathode, 8'hFF);
    chk("midreset_frame_start", {7'd0, frame_start}, 8'd0);
    @(negedge clk);
    value = 16'h1234;
    rst_n = 1'b1;
    wait_frame("f5");
    check_frame("f5_after_reset", 32'hF9_A4_B0_99, 4'hF, 32'hF9_A4_B0_99, 4'hF, 1'b0, 16'h0);

    // Leading-zero blanking
    value    = 16'h0070;
    lz_blank = 1'b1;
    wait_frame("f6");
    check_frame("f6_lz0070", 32'hFF_FF_F8_C0, 4'b0011, 32'hFF_FF_F8_C0, 4'b0011, 1'b0, 16'h0);
    value = 16'h0000;
    wait_frame("f7");
    check_frame("f7_lz0000", 32'hFF_FF_FF_C0, 4'b0001, 32'hFF_FF_FF_C0, 4'b0001, 1'b0, 16'h0);

    // Hex code on digit 0: A with HEX_EN=1, blank segments with HEX_EN=0
    value    = 16'h000A;
    lz_blank = 1'b0;
    wait_frame("f8");
    check_frame("f8_hexA", 32'hC0_C0_C0_88, 4'hF, 32'hC0_C0_C0_FF, 4'hF, 1'b0, 16'h0);

    // Decimal point on digit 1, digit 2 disabled
    value    = 16'h1234;
    dp       = 4'b0010;
    digit_en = 4'b1011;
    wait_frame("f9");
    check_frame("f9_dp_en", 32'hF9_FF_30_99, 4'b1011, 32'hF9_FF_30_99, 4'b1011, 1'b0, 16'h0);
    wait_frame("f10");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
